// File: rtl/rca_eval_pkg.sv
// Shared definitions for the approximate-adder characterization stages:
// operand/sum widths, the batch FSM state type and width helpers.
package rca_eval_pkg;

  localparam int unsigned OP_W  = 9;
  localparam int unsigned SUM_W = OP_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // log2 of a power-of-two batch length
  function automatic int unsigned ln_of(input int unsigned n);
    return $clog2(n);
  endfunction

  // Width of an accumulator that sums n values of sum_w bits without overflow
  function automatic int unsigned acc_w(input int unsigned sum_w, input int unsigned n);
    return sum_w + $clog2(n);
  endfunction

endpackage

// File: rtl/error_distance.sv
// Combinational error distance between the exact sum a+b and an approximate sum.
module error_distance #(
  parameter int unsigned OP_W = rca_eval_pkg::OP_W
) (
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic [OP_W:0]   s_apx,
  output logic [OP_W:0]   ed,
  output logic            nz
);

  logic [OP_W:0] exact_c;

  // Absolute difference so an over-estimating adder also yields a positive distance
  always_comb begin
    exact_c = {1'b0, a} + {1'b0, b};
    ed      = (exact_c >= s_apx) ? (exact_c - s_apx) : (s_apx - exact_c);
    nz      = |ed;
  end

endmodule

// File: rtl/rca_error_monitor.sv
// Batch error-statistics monitor for the approximate ripple-carry adder:
// two-stage pipeline into accumulators, results held until the next start.
module rca_error_monitor #(
  parameter  int unsigned N_SAMPLES = 256,
  parameter  int unsigned OP_W      = rca_eval_pkg::OP_W,
  localparam int unsigned LN        = rca_eval_pkg::ln_of(N_SAMPLES),
  localparam int unsigned SUM_W     = OP_W + 1,
  localparam int unsigned ACC_W     = rca_eval_pkg::acc_w(OP_W + 1, N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [SUM_W-1:0] s_apx,
  output logic             busy,
  output logic             done,
  output logic [LN:0]      err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [SUM_W-1:0] max_ed,
  output logic [SUM_W-1:0] med
);
  import rca_eval_pkg::*;

  localparam int unsigned CNT_W = LN + 1;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
  logic               p1_valid_q, p1_valid_d;
  logic [OP_W-1:0]    p1_a_q, p1_a_d, p1_b_q, p1_b_d;
  logic [SUM_W-1:0]   p1_s_q, p1_s_d;
  logic               p2_valid_q, p2_valid_d;
  logic               p2_nz_q, p2_nz_d;
  logic [SUM_W-1:0]   p2_ed_q, p2_ed_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
  logic [SUM_W-1:0]   max_ed_q, max_ed_d;
  logic [SUM_W-1:0]   med_q, med_d;
  logic [SUM_W-1:0]   ed_c;
  logic               nz_c;
  logic               accept_c, restart_c, last_commit_c;

  error_distance #(.OP_W(OP_W)) u_error_distance (
    .a     (p1_a_q),
    .b     (p1_b_q),
    .s_apx (p1_s_q),
    .ed    (ed_c),
    .nz    (nz_c)
  );

  // Next-state, pipeline advance and accumulation
  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    com_cnt_d   = com_cnt_q;
    p1_valid_d  = 1'b0;
    p1_a_d      = p1_a_q;
    p1_b_d      = p1_b_q;
    p1_s_d      = p1_s_q;
    p2_valid_d  = p1_valid_q;
    p2_nz_d     = p2_nz_q;
    p2_ed_d     = p2_ed_q;
    err_count_d = err_count_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;

    accept_c      = in_valid && in_ready_q;
    restart_c     = start && (state_q != ST_RUN);
    last_commit_c = p2_valid_q && (com_cnt_q == N_CNT - CNT_W'(1));

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_commit_c) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      p1_valid_d = 1'b1;
      p1_a_d     = a;
      p1_b_d     = b;
      p1_s_d     = s_apx;
      acc_cnt_d  = acc_cnt_q + CNT_W'(1);
    end

    if (p1_valid_q) begin
      p2_ed_d = ed_c;
      p2_nz_d = nz_c;
    end

    if (p2_valid_q) begin
      com_cnt_d   = com_cnt_q + CNT_W'(1);
      err_count_d = err_count_q + CNT_W'(p2_nz_q);
      sum_ed_d    = sum_ed_q + ACC_W'(p2_ed_q);
      if (p2_ed_q > max_ed_q) max_ed_d = p2_ed_q;
    end

    // A new batch wipes the previous batch's statistics at the start edge
    if (restart_c) begin
      acc_cnt_d   = '0;
      com_cnt_d   = '0;
      p1_valid_d  = 1'b0;
      p2_valid_d  = 1'b0;
      err_count_d = '0;
      sum_ed_d    = '0;
      max_ed_d    = '0;
    end

    in_ready_d = (state_d == ST_RUN) && (acc_cnt_d < N_CNT);
    busy_d     = (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
    med_d      = SUM_W'(sum_ed_d >> LN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_cnt_q   <= '0;
      com_cnt_q   <= '0;
      p1_valid_q  <= 1'b0;
      p1_a_q      <= '0;
      p1_b_q      <= '0;
      p1_s_q      <= '0;
      p2_valid_q  <= 1'b0;
      p2_nz_q     <= 1'b0;
      p2_ed_q     <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      med_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      com_cnt_q   <= com_cnt_d;
      p1_valid_q  <= p1_valid_d;
      p1_a_q      <= p1_a_d;
      p1_b_q      <= p1_b_d;
      p1_s_q      <= p1_s_d;
      p2_valid_q  <= p2_valid_d;
      p2_nz_q     <= p2_nz_d;
      p2_ed_q     <= p2_ed_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      med_q       <= med_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_count_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign med       = med_q;

endmodule

// File: tb/tb_rca_error_monitor.sv
// Directed and randomized batches for rca_error_monitor against an arithmetic reference.
module tb_rca_error_monitor;

  localparam int unsigned N    = 4;
  localparam int unsigned OPW  = 9;

  typedef logic [OPW-1:0] op_arr_t [N];
  typedef logic [OPW:0]   sum_arr_t [N];

  logic           clk = 1'b0;
  logic           rst_n, start, in_valid;
  logic [OPW-1:0] a, b;
  logic [OPW:0]   s_apx;
  logic           in_ready, busy, done;
  logic [2:0]     err_count;
  logic [11:0]    sum_ed;
  logic [OPW:0]   max_ed, med;

  int vectors = 0;
  int miscompares = 0;
  int exp_err, exp_sum, exp_max;

  rca_error_monitor #(.N_SAMPLES(N), .OP_W(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s_apx     (s_apx),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .sum_ed    (sum_ed),
    .max_ed    (max_ed),
    .med       (med)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: batch statistics straight from the definitions
  task automatic model_clear();
    exp_err = 0;
    exp_sum = 0;
    exp_max = 0;
  endtask

  task automatic model_add(input int va, input int vb, input int vs);
    int ed;
    ed = (va + vb) - vs;
    if (ed < 0) ed = -ed;
    if (ed != 0) exp_err++;
    exp_sum += ed;
    if (ed > exp_max) exp_max = ed;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    chk({tag, ".sum_ed"},    32'(sum_ed),    32'(exp_sum));
    chk({tag, ".max_ed"},    32'(max_ed),    32'(exp_max));
    chk({tag, ".med"},       32'(med),       32'(exp_sum / int'(N)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".err_count"}, 32'(err_count), 32'd0);
    chk({tag, ".sum_ed"},    32'(sum_ed),    32'd0);
    chk({tag, ".max_ed"},    32'(max_ed),    32'd0);
    chk({tag, ".med"},       32'(med),       32'd0);
  endtask

  task automatic run_batch(input string tag, input op_arr_t va, input op_arr_t vb,
                           input sum_arr_t vs, input bit do_start, input int gmin,
                           input int gmax, input bit extra, input bit mid_start,
                           input bit chain);
    int t;
    model_clear();
    for (int i = 0; i < int'(N); i++) model_add(int'(va[i]), int'(vb[i]), int'(vs[i]));
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
      chk({tag, ".ready_after_start"}, 32'(in_ready), 32'd1);
    end
    for (int i = 0; i < int'(N); i++) begin
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      s_apx = vs[i];
      t = 0;
      while (!in_ready && t < 20) begin
        step();
        t++;
      end
      chk({tag, ".in_ready_wait"}, 32'(in_ready), 32'd1);
      if (mid_start && i == 2) start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b0;
      if (i != int'(N) - 1) begin
        t = $urandom_range(gmax, gmin);
        for (int g = 0; g < t; g++) step();
      end
    end
    chk({tag, ".ready_drop"}, 32'(in_ready), 32'd0);
    if (extra) begin
      in_valid = 1'b1;
      a = 9'd1;
      b = 9'd2;
      s_apx = 10'd0;
    end
    step();
    chk({tag, ".done_early"}, 32'(done), 32'd0);
    chk({tag, ".busy_e1"}, 32'(busy), 32'd1);
    chk({tag, ".ready_e1"}, 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk({tag, ".ready_done"}, 32'(in_ready), 32'd0);
    chk_results(tag);
    if (chain) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, ".chain_busy"}, 32'(busy), 32'd1);
      chk({tag, ".chain_done"}, 32'(done), 32'd0);
      chk({tag, ".chain_ready"}, 32'(in_ready), 32'd1);
      chk_zero({tag, ".chain"});
    end else begin
      step();
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      chk_results({tag, ".hold"});
    end
  endtask

  initial begin
    op_arr_t  ra, rb;
    sum_arr_t rs;
    bit       chained;
    int       ex;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; s_apx = '0;
    step();
    step();
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // Reset in the middle of a batch after two accepts
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 9'd15; b = 9'd1; s_apx = 10'd0;
    step();
    a = 9'd3; b = 9'd3; s_apx = 10'd7;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    chk_zero("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst.idle_ready", 32'(in_ready), 32'd0);
    chk("midrst.idle_busy", 32'(busy), 32'd0);
    chk_zero("midrst.idle");

    ra = '{9'd100, 9'd100, 9'd100, 9'd100};
    rb = '{9'd55, 9'd55, 9'd55, 9'd55};
    rs = '{10'd155, 10'd155, 10'd155, 10'd155};
    run_batch("exact", ra, rb, rs, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    ra = '{9'd15, 9'd3, 9'd10, 9'd511};
    rb = '{9'd1, 9'd3, 9'd10, 9'd511};
    rs = '{10'd0, 10'd7, 10'd20, 10'd1020};
    run_batch("mixed", ra, rb, rs, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_batch("backpressure", ra, rb, rs, 1'b1, 1, 3, 1'b1, 1'b0, 1'b0);

    ra = '{9'd0, 9'd7, 9'd200, 9'd1};
    rb = '{9'd0, 9'd8, 9'd300, 9'd2};
    rs = '{10'd15, 10'd15, 10'd500, 10'd3};
    run_batch("above", ra, rb, rs, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);

    ra = '{9'd15, 9'd3, 9'd10, 9'd511};
    rb = '{9'd1, 9'd3, 9'd10, 9'd511};
    rs = '{10'd0, 10'd7, 10'd20, 10'd1020};
    run_batch("control", ra, rb, rs, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0);

    chained = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bit ch;
      for (int i = 0; i < int'(N); i++) begin
        ra[i] = OPW'($urandom);
        rb[i] = OPW'($urandom);
        ex = int'(ra[i]) + int'(rb[i]);
        case ($urandom_range(2, 0))
          0:       rs[i] = 10'(ex);
          1:       rs[i] = 10'(ex ^ int'($urandom_range(31, 0)));
          default: rs[i] = 10'($urandom);
        endcase
      end
      ch = (k != 5) && ($urandom_range(1, 0) == 1);
      run_batch($sformatf("rand%0d", k), ra, rb, rs, !chained, 0, 2, ($urandom_range(1, 0) == 1),
                ($urandom_range(1, 0) == 1), ch);
      chained = ch;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
